// File: rtl/gated_count_bank.sv
// gated_count_bank: gated pulse counter that latches each window total into a bank of hold registers
// with per-channel valid/overflow flags, done/sel_err strobes and an activity toggle.
module gated_count_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter bit SATURATE = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      gate,
    input  logic                      pulse,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       ack,
    input  logic                      clear,
    output logic [WIDTH-1:0]          live_count,
    output logic [CHANNELS*WIDTH-1:0] hold_data,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       ovf,
    output logic                      done,
    output logic                      sel_err,
    output logic                      activity
);
    typedef enum logic [1:0] {IDLE, COUNT, LATCH} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic                wovf_q, wovf_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [WIDTH-1:0]    hold_q [CHANNELS];
    logic [WIDTH-1:0]    hold_d [CHANNELS];
    logic [CHANNELS-1:0] valid_q, valid_d, ovf_q, ovf_d, wr_ch;
    logic                done_q, done_d, sel_err_q, sel_err_d, activity_q, activity_d;
    logic                counted, at_max, in_range, write;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = clear ? IDLE :
                  state_q == IDLE  ? (gate ? COUNT : IDLE) :
                  state_q == COUNT ? (gate ? COUNT : LATCH) : IDLE;
    end

    always_comb begin
        counted    = !clear && gate && pulse && (state_q == IDLE || state_q == COUNT);
        at_max     = &acc_q;
        in_range   = 32'(sel_q) < CHANNELS;
        write      = !clear && state_q == LATCH && in_range;
        acc_d      = (clear || state_q == LATCH) ? '0 :
                     state_q == IDLE ? (gate ? WIDTH'(pulse) : '0) :
                     counted ? (at_max ? (SATURATE ? acc_q : '0) : acc_q + WIDTH'(1)) : acc_q;
        // window overflow survives into LATCH, where it is copied out, then drops
        wovf_d     = (clear || state_q != COUNT) ? 1'b0 : wovf_q | (counted && at_max);
        sel_d      = clear ? '0 : (state_q == COUNT && !gate) ? sel : sel_q;
        done_d     = write;
        sel_err_d  = !clear && state_q == LATCH && !in_range;
        activity_d = activity_q ^ counted;
        wr_ch      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ch[c]   = write && 32'(sel_q) == c;
            hold_d[c]  = clear ? '0 : wr_ch[c] ? acc_q : hold_q[c];
            valid_d[c] = !clear && (wr_ch[c] || (valid_q[c] && !ack[c]));
            ovf_d[c]   = clear ? 1'b0 : wr_ch[c] ? wovf_q : ovf_q[c];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            wovf_q     <= 1'b0;
            sel_q      <= '0;
            valid_q    <= '0;
            ovf_q      <= '0;
            done_q     <= 1'b0;
            sel_err_q  <= 1'b0;
            activity_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) hold_q[c] <= '0;
        end else begin
            acc_q      <= acc_d;
            wovf_q     <= wovf_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            sel_err_q  <= sel_err_d;
            activity_q <= activity_d;
            for (int c = 0; c < CHANNELS; c++) hold_q[c] <= hold_d[c];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
        assign hold_data[g*WIDTH +: WIDTH] = hold_q[g];
    end

    assign live_count = acc_q;
    assign valid      = valid_q;
    assign ovf        = ovf_q;
    assign done       = done_q;
    assign sel_err    = sel_err_q;
    assign activity   = activity_q;
endmodule

// File: tb/tb_gated_count_bank.sv
// tb_gated_count_bank: saturating and wrapping instances driven in lock step; window totals are
// modelled as plain pulse counts and checked through a queue drained by a negedge monitor.
module tb_gated_count_bank;
    localparam int W = 4, CH = 3, SW = 2, MAXV = 15;

    logic clock = 0, reset_n = 1, gate = 0, pulse = 0, clear = 0;
    logic [SW-1:0]   sel = '0;
    logic [CH-1:0]   ack = '0;
    logic [W-1:0]    live [2];
    logic [CH*W-1:0] hd   [2];
    logic [CH-1:0]   vld  [2];
    logic [CH-1:0]   ov   [2];
    logic            dn   [2];
    logic            se   [2];
    logic            act  [2];

    always #5 clock = ~clock;

    gated_count_bank #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .SATURATE(1'b1)) dut_sat (
        .clock(clock), .reset_n(reset_n), .gate(gate), .pulse(pulse), .sel(sel), .ack(ack),
        .clear(clear), .live_count(live[0]), .hold_data(hd[0]), .valid(vld[0]), .ovf(ov[0]),
        .done(dn[0]), .sel_err(se[0]), .activity(act[0]));

    gated_count_bank #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .SATURATE(1'b0)) dut_wrap (
        .clock(clock), .reset_n(reset_n), .gate(gate), .pulse(pulse), .sel(sel), .ack(ack),
        .clear(clear), .live_count(live[1]), .hold_data(hd[1]), .valid(vld[1]), .ovf(ov[1]),
        .done(dn[1]), .sel_err(se[1]), .activity(act[1]));

    typedef struct {int cyc; int ch; int n;} item_t;
    item_t q[$];
    int cyc = 0, exp_n = 0, tot = 0, n_cmp = 0, n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // expected register value after n pulses: instance 0 saturates, instance 1 wraps
    function automatic int f(input int d, input int n);
        return d == 0 ? (n > MAXV ? MAXV : n) : n % (MAXV + 1);
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d at cycle %0d", nm, d, a, e, cyc);
        end
    endtask

    int          eh [2][CH];
    logic [CH-1:0] ev = '0, eo = '0, ack_p = '0;
    logic        clr_p = 0;

    always @(negedge clock) begin
        item_t it;
        logic ed, ee;
        ed = 0;
        ee = 0;
        if (!reset_n || clr_p) begin
            ev = '0;
            eo = '0;
            for (int d = 0; d < 2; d++) for (int c = 0; c < CH; c++) eh[d][c] = 0;
        end
        if (reset_n) begin
            ev &= ~ack_p;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                it = q.pop_front();
                if (it.ch < CH) begin
                    ed = 1;
                    ev[it.ch] = 1'b1;
                    eo[it.ch] = it.n > MAXV;
                    for (int d = 0; d < 2; d++) eh[d][it.ch] = f(d, it.n);
                end else ee = 1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk("live_count", d, 32'(live[d]), f(d, exp_n));
            chk("activity", d, 32'(act[d]), tot % 2);
            chk("done", d, 32'(dn[d]), 32'(ed));
            chk("sel_err", d, 32'(se[d]), 32'(ee));
            chk("valid", d, 32'(vld[d]), 32'(ev));
            chk("ovf", d, 32'(ov[d]), 32'(eo));
            for (int c = 0; c < CH; c++) chk("hold_data", d, 32'(hd[d][c*W +: W]), eh[d][c]);
        end
        ack_p = ack;
        clr_p = clear;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [CH-1:0] rnd_ack();
        return $urandom_range(0, 3) == 0 ? CH'($urandom) : '0;
    endfunction

    // pm: 0 random pulses, 1 pulse every cycle, 2 alternate starting on the first cycle
    // kill >= 0: clear (or reset when rst) during that gate-high cycle, restarting the count
    task automatic window(input int len, input int pm, input int sv, input int glow,
                          input int kill, input bit rst);
        int n = 0;
        for (int i = 0; i < len; i++) begin
            gate  = 1;
            pulse = pm == 1 ? 1'b1 : pm == 2 ? (i % 2 == 0) : 1'($urandom);
            sel   = SW'($urandom);
            ack   = rnd_ack();
            clear = i == kill && !rst;
            if (i == kill && rst) begin
                reset_n = 0;
                n = 0;
                tot = 0;
                exp_n = 0;
            end
            step();
            if (i == kill) begin
                n = 0;
                reset_n = 1;
            end else if (pulse) begin
                n++;
                tot++;
            end
            exp_n = n;
        end
        clear = 0;
        for (int j = 0; j < glow; j++) begin
            gate  = 0;
            pulse = 1'($urandom);
            sel   = j == 0 ? SW'(sv) : SW'($urandom);
            ack   = rnd_ack();
            step();
            if (j == 0) q.push_back('{cyc + 1, sv, n});
            if (j == 1) exp_n = 0;
        end
    endtask

    initial begin
        #1 reset_n = 0;
        repeat (3) step();
        reset_n = 1;
        step();
        window(10, 1, 2, 2, -1, 0);
        window(8, 2, 0, 3, -1, 0);
        window(3, 1, 1, 2, -1, 0);
        window(20, 1, 0, 2, -1, 0);
        window(16, 1, 1, 2, -1, 0);
        window(15, 1, 2, 2, -1, 0);
        window(5, 0, 3, 2, -1, 0);
        window(12, 1, 2, 2, 5, 0);
        window(12, 1, 1, 3, 4, 1);
        for (int k = 0; k < 60; k++) begin
            int len, kl;
            len = $urandom_range(1, 24);
            kl  = (len >= 3 && $urandom_range(0, 7) == 0) ? $urandom_range(0, len - 2) : -1;
            window(len, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(2, 4),
                   kl, 1'($urandom));
        end
        repeat (4) step();
        chk("queue_drained", 0, q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end
endmodule
